// File: rtl/tdma_pkg.sv
// Shared DMA command constants: command word width and default command FIFO depth.
// No logic; latency n/a; backpressure n/a.
package tdma_pkg;

    // 2 x 64-bit addresses, 8 x 32-bit fields, 5 x 32-bit control words
    localparam int unsigned TDMA_CMD_WIDTH  = 2*64 + 8*32 + 5*32;
    localparam int unsigned TDMA_FIFO_DEPTH = 8;

endpackage

// File: rtl/tdma_cmd_fifo.sv
// Command FIFO between config interface and DMA frontend; optional checks via TDMA_FIFO_CHECKS_EN.
// Latency: 1 cycle push-to-data_o, 0 cycles into an empty FIFO when FALL_THROUGH=1.
// Backpressure: full_o drops pushes, empty_o drops pops, flush_i overrides both.
module tdma_cmd_fifo
    import tdma_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = TDMA_FIFO_DEPTH,
    parameter int unsigned THRESHOLD    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  threshold_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESHOLD);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic count_zero, bypass, bypass_pop, push_acc, pop_acc, do_write, do_read;
    logic unused_testmode;

    assign unused_testmode = testmode_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    assign count_zero  = (count_q == '0);
    assign bypass      = FALL_THROUGH && count_zero && push_i;
    assign full_o      = (count_q == DEPTH_C);
    assign threshold_o = (count_q >= THR_C);
    assign empty_o     = count_zero && !bypass;
    assign data_o      = bypass ? data_i : mem_q[rd_ptr_q];

    assign push_acc   = push_i && !full_o;
    assign pop_acc    = pop_i && !empty_o;
    // A word that enters and leaves an empty FIFO in one cycle never touches storage
    assign bypass_pop = bypass && pop_i;
    assign do_write   = push_acc && !bypass_pop;
    assign do_read    = pop_acc && !bypass_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_read) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_write && !do_read) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_read && !do_write) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef TDMA_FIFO_CHECKS_EN
    push_full_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !flush_i))
        else $error("tdma_cmd_fifo: push while full");

    pop_empty_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o))
        else $error("tdma_cmd_fifo: pop while empty");

    if (DEPTH < 1 || DEPTH > 127 || THRESHOLD > DEPTH) begin : g_bad_param
        $error("tdma_cmd_fifo: DEPTH must be 1..127 and THRESHOLD <= DEPTH");
    end
`endif

endmodule

// File: tb/tb_tdma_cmd_fifo.sv
// Directed bench: a one-cycle-latency instance and a fall-through instance, both DEPTH=4, THRESHOLD=2.
module tb_tdma_cmd_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        testmode_i = 1'b0;

    logic        flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        full_o, empty_o, threshold_o;
    logic [31:0] data_o;

    logic        ft_flush_i = 1'b0, ft_push_i = 1'b0, ft_pop_i = 1'b0;
    logic [31:0] ft_data_i = '0;
    logic        ft_full_o, ft_empty_o, ft_threshold_o;
    logic [31:0] ft_data_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    tdma_cmd_fifo #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(4), .THRESHOLD(2)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .testmode_i(testmode_i),
        .full_o(full_o), .empty_o(empty_o), .threshold_o(threshold_o),
        .data_i(data_i), .push_i(push_i), .data_o(data_o), .pop_i(pop_i)
    );

    tdma_cmd_fifo #(.FALL_THROUGH(1'b1), .DATA_WIDTH(32), .DEPTH(4), .THRESHOLD(2)) u_dut_ft (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(ft_flush_i), .testmode_i(testmode_i),
        .full_o(ft_full_o), .empty_o(ft_empty_o), .threshold_o(ft_threshold_o),
        .data_i(ft_data_i), .push_i(ft_push_i), .data_o(ft_data_o), .pop_i(ft_pop_i)
    );

    task automatic test_reset;
        #12;
        total++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b exp 1", empty_o); else passed++;
        total++; if (full_o !== 1'b0) $display("FAIL reset_full: got %b exp 0", full_o); else passed++;
        total++; if (threshold_o !== 1'b0) $display("FAIL reset_thr: got %b exp 0", threshold_o); else passed++;
        total++; if (data_o !== 32'h0) $display("FAIL reset_data: got %h exp 00000000", data_o); else passed++;
        total++; if (ft_empty_o !== 1'b1) $display("FAIL reset_ft_empty: got %b exp 1", ft_empty_o); else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_fill_drain;
        logic [31:0] vals [5] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4, 32'hEE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (i > 0) begin
                total++; if (threshold_o !== (i >= 2)) $display("FAIL fill_thr[%0d]: got %b exp %b", i, threshold_o, (i >= 2)); else passed++;
                total++; if (full_o !== (i >= 4)) $display("FAIL fill_full[%0d]: got %b exp %b", i, full_o, (i >= 4)); else passed++;
                total++; if (empty_o !== 1'b0) $display("FAIL fill_empty[%0d]: got %b exp 0", i, empty_o); else passed++;
            end
            data_i = vals[i];
            push_i = 1'b1;
        end
        @(negedge clk_i);
        push_i = 1'b0;
        total++; if (full_o !== 1'b1) $display("FAIL drop_full: got %b exp 1", full_o); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            total++; if (data_o !== vals[i]) $display("FAIL drain_data[%0d]: got %h exp %h", i, data_o, vals[i]); else passed++;
            pop_i = 1'b1;
        end
        @(negedge clk_i);
        pop_i = 1'b0;
        total++; if (empty_o !== 1'b1) $display("FAIL drain_empty: got %b exp 1", empty_o); else passed++;
        total++; if (full_o !== 1'b0) $display("FAIL drain_full: got %b exp 0", full_o); else passed++;
        total++; if (threshold_o !== 1'b0) $display("FAIL drain_thr: got %b exp 0", threshold_o); else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk_i);
        push_i = 1'b1; data_i = 32'h10;
        @(negedge clk_i);
        data_i = 32'h11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            total++; if (data_o !== 32'h10 + k) $display("FAIL b2b_data[%0d]: got %h exp %h", k, data_o, 32'h10 + k); else passed++;
            total++; if (threshold_o !== 1'b1 || full_o !== 1'b0) $display("FAIL b2b_level[%0d]: got thr=%b full=%b exp thr=1 full=0", k, threshold_o, full_o); else passed++;
            push_i = 1'b1; pop_i = 1'b1; data_i = 32'h12 + k;
        end
        @(negedge clk_i);
        push_i = 1'b0;
        total++; if (data_o !== 32'h1A) $display("FAIL b2b_tail0: got %h exp 0000001a", data_o); else passed++;
        @(negedge clk_i);
        total++; if (data_o !== 32'h1B) $display("FAIL b2b_tail1: got %h exp 0000001b", data_o); else passed++;
        @(negedge clk_i);
        pop_i = 1'b0;
        total++; if (empty_o !== 1'b1) $display("FAIL b2b_empty: got %b exp 1", empty_o); else passed++;
    endtask

    task automatic test_fall_through;
        @(negedge clk_i);
        ft_push_i = 1'b1; ft_pop_i = 1'b1; ft_data_i = 32'h55;
        #1;
        total++; if (ft_data_o !== 32'h55) $display("FAIL ft_bypass_data: got %h exp 00000055", ft_data_o); else passed++;
        total++; if (ft_empty_o !== 1'b0) $display("FAIL ft_bypass_empty: got %b exp 0", ft_empty_o); else passed++;
        @(negedge clk_i);
        ft_push_i = 1'b0; ft_pop_i = 1'b0;
        #1;
        total++; if (ft_empty_o !== 1'b1) $display("FAIL ft_after_empty: got %b exp 1", ft_empty_o); else passed++;
        // Push alone: visible at once, then stored; head must be 0x66, not the bypassed 0x55
        @(negedge clk_i);
        ft_push_i = 1'b1; ft_data_i = 32'h66;
        #1;
        total++; if (ft_data_o !== 32'h66) $display("FAIL ft_push_data: got %h exp 00000066", ft_data_o); else passed++;
        @(negedge clk_i);
        ft_push_i = 1'b0;
        #1;
        total++; if (ft_empty_o !== 1'b0 || ft_data_o !== 32'h66) $display("FAIL ft_stored: got empty=%b data=%h exp empty=0 data=00000066", ft_empty_o, ft_data_o); else passed++;
        ft_pop_i = 1'b1;
        @(negedge clk_i);
        ft_pop_i = 1'b0;
        #1;
        total++; if (ft_empty_o !== 1'b1) $display("FAIL ft_pop_empty: got %b exp 1", ft_empty_o); else passed++;
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            push_i = 1'b1; data_i = 32'h31 + i;
        end
        @(negedge clk_i);
        data_i = 32'h34; flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        total++; if (empty_o !== 1'b1 || threshold_o !== 1'b0) $display("FAIL flush_level: got empty=%b thr=%b exp empty=1 thr=0", empty_o, threshold_o); else passed++;
        data_i = 32'h35;
        @(negedge clk_i);
        push_i = 1'b0;
        total++; if (data_o !== 32'h35 || empty_o !== 1'b0) $display("FAIL flush_next: got data=%h empty=%b exp data=00000035 empty=0", data_o, empty_o); else passed++;
        pop_i = 1'b1;
        @(negedge clk_i);
        pop_i = 1'b0;
        total++; if (empty_o !== 1'b1) $display("FAIL flush_drain: got %b exp 1", empty_o); else passed++;
    endtask

    task automatic test_pop_empty;
        @(negedge clk_i);
        pop_i = 1'b1;
        repeat (2) @(negedge clk_i);
        pop_i = 1'b0;
        total++; if (empty_o !== 1'b1 || full_o !== 1'b0 || threshold_o !== 1'b0) $display("FAIL pop_empty_state: got empty=%b full=%b thr=%b exp 1 0 0", empty_o, full_o, threshold_o); else passed++;
        push_i = 1'b1; data_i = 32'h77;
        @(negedge clk_i);
        push_i = 1'b0;
        total++; if (data_o !== 32'h77 || empty_o !== 1'b0 || threshold_o !== 1'b0) $display("FAIL pop_empty_push: got data=%h empty=%b thr=%b exp 00000077 0 0", data_o, empty_o, threshold_o); else passed++;
        pop_i = 1'b1;
        @(negedge clk_i);
        pop_i = 1'b0;
    endtask

    task automatic test_reset_midfill;
        @(negedge clk_i);
        push_i = 1'b1; data_i = 32'h81;
        @(negedge clk_i);
        data_i = 32'h82;
        @(negedge clk_i);
        push_i = 1'b0;
        total++; if (empty_o !== 1'b0 || threshold_o !== 1'b1) $display("FAIL midfill_level: got empty=%b thr=%b exp 0 1", empty_o, threshold_o); else passed++;
        #2;
        rst_ni = 1'b0;
        #1;
        total++; if (empty_o !== 1'b1 || threshold_o !== 1'b0) $display("FAIL async_reset_level: got empty=%b thr=%b exp 1 0", empty_o, threshold_o); else passed++;
        total++; if (data_o !== 32'h0) $display("FAIL async_reset_data: got %h exp 00000000", data_o); else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        total++; if (empty_o !== 1'b1) $display("FAIL post_reset_empty: got %b exp 1", empty_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_fall_through();
        test_flush();
        test_pop_empty();
        test_reset_midfill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
